// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_pkg                                                   |
// | Purpose  : Shared types and constants for the MAR/MDR memory         |
// |            responder (FSM states, op codes, bus/wait limits).        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package mem_pkg;

   localparam int MEM_DATA_W   = 32;
   localparam int MEM_MAX_WAIT = 15;
   localparam int MEM_CNT_W    = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      DONE   = 2'd3
   } mem_state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } mem_op_t;

   // Clamp a wait-state parameter into the range the counter can hold.
   function automatic logic [MEM_CNT_W-1:0] wait_init(input int ws);
      if (ws <= 0)
         return '0;
      else if (ws >= MEM_MAX_WAIT)
         return MEM_CNT_W'(MEM_MAX_WAIT);
      else
         return MEM_CNT_W'(ws);
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ram_array                                                 |
// | Purpose  : Synchronous single-port word RAM, write enable plus       |
// |            read enable, registered (one-cycle) read data.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ram_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int c_depth = 1 << ADDR_W;

   logic [DATA_W-1:0] r_mem [0:c_depth-1];
   logic [DATA_W-1:0] r_rdata;

   // Array write and read-data register; contents are never reset.
   always_ff @(posedge clk) begin
      if (we)
         r_mem[addr] <= wdata;
      if (re)
         r_rdata <= r_mem[addr];
   end

   assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : mem_responder                                             |
// | Purpose  : Memory-side responder for the MAR/MDR interface. Accepts  |
// |            one read or write in IDLE, waits WAIT_STATES cycles,      |
// |            accesses the internal RAM and pulses mem_done.            |
// | Options  : MEM_VALID_EN adds per-word valid bits and rd_uninit.      |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = MEM_DATA_W,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              Read,
   input  logic              Write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] Mdatain,
   output logic              mem_done,
   output logic              busy,
`ifdef MEM_VALID_EN
   output logic              req_err,
   output logic              rd_uninit
`else
   output logic              req_err
`endif
);

   localparam logic [MEM_CNT_W-1:0] c_wait_init = wait_init(WAIT_STATES);

   mem_state_t           r_state;
   mem_state_t           w_state_nxt;
   logic [MEM_CNT_W-1:0] r_wait_cnt;
   logic [ADDR_W-1:0]    r_addr;
   logic [DATA_W-1:0]    r_wdata;
   mem_op_t              r_op;
   logic                 r_req_err;
   logic                 r_rd_mask;
   logic                 w_accept;
   logic                 w_conflict;
   logic                 w_ram_we;
   logic                 w_ram_re;
   logic                 w_rd_zero;
   logic [DATA_W-1:0]    w_ram_rdata;

   assign w_accept   = (r_state == IDLE) && (Read ^ Write);
   assign w_conflict = (r_state == IDLE) && Read && Write;

   // State register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic; WAIT is skipped entirely when no wait states are configured.
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (w_accept)
                     w_state_nxt = (c_wait_init == '0) ? ACCESS : WAIT;
         WAIT:    if (r_wait_cnt <= MEM_CNT_W'(1))
                     w_state_nxt = ACCESS;
         ACCESS:  w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State-decoded outputs and RAM strobes.
   always_comb begin
      busy     = (r_state != IDLE);
      mem_done = (r_state == DONE);
      w_ram_we = (r_state == ACCESS) && (r_op == OP_WR);
      w_ram_re = (r_state == ACCESS) && (r_op == OP_RD);
   end

   // Request capture and wait counter; inputs are ignored once a request is held.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_wait_cnt <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_op       <= OP_RD;
      end else if (w_accept) begin
         r_wait_cnt <= c_wait_init;
         r_addr     <= addr;
         r_wdata    <= wdata;
         r_op       <= Write ? OP_WR : OP_RD;
      end else if (r_state == WAIT) begin
         r_wait_cnt <= r_wait_cnt - MEM_CNT_W'(1);
      end
   end

   // One-cycle error pulse for a request that asserts both Read and Write.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         r_req_err <= 1'b0;
      else
         r_req_err <= w_conflict;
   end

   assign req_err = r_req_err;

   ram_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk   (clk),
      .we    (w_ram_we),
      .re    (w_ram_re),
      .addr  (r_addr),
      .wdata (r_wdata),
      .rdata (w_ram_rdata)
   );

`ifdef MEM_VALID_EN
   localparam int c_depth = 1 << ADDR_W;

   logic [c_depth-1:0] r_valid;
   logic               r_rd_uninit;

   // Per-word valid bits, set by the committing write, cleared only by reset.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         r_valid <= '0;
      else if (w_ram_we)
         r_valid[r_addr] <= 1'b1;
   end

   assign w_rd_zero = ~r_valid[r_addr];

   // Flag a read of a never-written word in the DONE cycle.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         r_rd_uninit <= 1'b0;
      else
         r_rd_uninit <= w_ram_re && w_rd_zero;
   end

   assign rd_uninit = r_rd_uninit;
`else
   assign w_rd_zero = 1'b0;
`endif

   // The RAM read register has no reset, so a mask forces Mdatain to zero
   // after reset and for invalid words until the next real read lands.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr)
         r_rd_mask <= 1'b1;
      else if (w_ram_re)
         r_rd_mask <= w_rd_zero;
   end

   assign Mdatain = r_rd_mask ? '0 : w_ram_rdata;

endmodule
`default_nettype wire
